// File: rtl/vga_pattern_source.sv
`default_nettype none
// vga_pattern_source: Avalon-ST 30-bit RGB test-pattern frame source with sop/eop framing.
// Rev 1.0
module vga_pattern_source #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [29:0] solid_color,
  output logic [29:0] stream_data,
  output logic        stream_startofpacket,
  output logic        stream_endofpacket,
  output logic        stream_valid,
  input  logic        stream_ready,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_STREAM = 1'b1;
  localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  logic [0:0]  state;
  logic [11:0] x, y, bar_cnt;
  logic [2:0]  bar_idx;
  logic [1:0]  sel_q;
  logic [29:0] color_q;

  logic [11:0] nx, ny, n_bar_cnt;
  logic [2:0]  n_bar_idx;
  logic [1:0]  n_sel;
  logic [29:0] n_color;
  logic [29:0] n_pixel;
  logic        last, n_sop, n_eop;

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Coordinates of the pixel to be presented after the next output update.
  always_comb begin
    nx        = x;
    ny        = y;
    n_bar_cnt = bar_cnt;
    n_bar_idx = bar_idx;
    n_sel     = sel_q;
    n_color   = color_q;
    if (state == S_IDLE || (stream_valid && last)) begin
      nx        = '0;
      ny        = '0;
      n_bar_cnt = '0;
      n_bar_idx = '0;
      n_sel     = pattern_sel;
      n_color   = solid_color;
    end else if (stream_valid) begin
      if (x == X_LAST) begin
        nx        = '0;
        ny        = y + 12'd1;
        n_bar_cnt = '0;
        n_bar_idx = '0;
      end else begin
        nx = x + 12'd1;
        if (bar_cnt == BAR_LAST) begin
          n_bar_cnt = '0;
          n_bar_idx = bar_idx + 3'd1;
        end else begin
          n_bar_cnt = bar_cnt + 12'd1;
        end
      end
    end
  end

  // Bar order W,Y,C,G,M,R,B,K maps to R=~idx[1], G=~idx[2], B=~idx[0].
  always_comb begin
    case (n_sel)
      2'd0:    n_pixel = {{10{~n_bar_idx[1]}}, {10{~n_bar_idx[2]}}, {10{~n_bar_idx[0]}}};
      2'd1:    n_pixel = {nx[9:0], nx[9:0], nx[9:0]};
      2'd2:    n_pixel = (nx[5] ^ ny[5]) ? 30'h0 : 30'h3FFFFFFF;
      default: n_pixel = n_color;
    endcase
    n_sop = (nx == 12'd0) && (ny == 12'd0);
    n_eop = (nx == X_LAST) && (ny == Y_LAST);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state                <= S_IDLE;
      x                    <= '0;
      y                    <= '0;
      bar_cnt              <= '0;
      bar_idx              <= '0;
      sel_q                <= '0;
      color_q              <= '0;
      stream_data          <= '0;
      stream_startofpacket <= 1'b0;
      stream_endofpacket   <= 1'b0;
      stream_valid         <= 1'b0;
      frame_count          <= '0;
      busy                 <= 1'b0;
    end else if (state == S_IDLE) begin
      if (enable) begin
        state   <= S_STREAM;
        busy    <= 1'b1;
        x       <= nx;
        y       <= ny;
        bar_cnt <= n_bar_cnt;
        bar_idx <= n_bar_idx;
        sel_q   <= n_sel;
        color_q <= n_color;
      end
    end else if (!stream_valid) begin
      // First beat of a frame entered from IDLE: present pixel (0,0).
      stream_valid         <= 1'b1;
      stream_data          <= n_pixel;
      stream_startofpacket <= n_sop;
      stream_endofpacket   <= n_eop;
    end else if (stream_ready) begin
      if (last) begin
        frame_count <= frame_count + 16'd1;
      end
      if (last && !enable) begin
        state                <= S_IDLE;
        busy                 <= 1'b0;
        stream_valid         <= 1'b0;
        stream_data          <= '0;
        stream_startofpacket <= 1'b0;
        stream_endofpacket   <= 1'b0;
      end else begin
        x                    <= nx;
        y                    <= ny;
        bar_cnt              <= n_bar_cnt;
        bar_idx              <= n_bar_idx;
        sel_q                <= n_sel;
        color_q              <= n_color;
        stream_data          <= n_pixel;
        stream_startofpacket <= n_sop;
        stream_endofpacket   <= n_eop;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_source.sv
`default_nettype none
// tb_vga_pattern_source: directed, table-driven checks of the pattern source framing and patterns.
// Rev 1.0
module tb_vga_pattern_source;

  localparam int HA = 16;
  localparam int VA = 4;
  localparam int HB = 64;
  localparam int VB = 64;
  localparam logic [29:0] WHITE = 30'h3FFFFFFF;
  localparam logic [29:0] SOLID = 30'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b, ready;
  logic [1:0]  sel;
  logic [29:0] color;

  logic [29:0] data_a, data_b;
  logic        sop_a, eop_a, valid_a, busy_a;
  logic        sop_b, eop_b, valid_b, busy_b;
  logic [15:0] fc_a, fc_b;

  vga_pattern_source #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .enable(en_a), .pattern_sel(sel), .solid_color(color),
    .stream_data(data_a), .stream_startofpacket(sop_a), .stream_endofpacket(eop_a),
    .stream_valid(valid_a), .stream_ready(ready), .frame_count(fc_a), .busy(busy_a)
  );

  vga_pattern_source #(.H_ACTIVE(HB), .V_ACTIVE(VB)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .enable(en_b), .pattern_sel(sel), .solid_color(color),
    .stream_data(data_b), .stream_startofpacket(sop_b), .stream_endofpacket(eop_b),
    .stream_valid(valid_b), .stream_ready(ready), .frame_count(fc_b), .busy(busy_b)
  );

  bit          use_b;
  logic [29:0] m_data;
  logic        m_sop, m_eop, m_valid;
  assign m_data  = use_b ? data_b  : data_a;
  assign m_sop   = use_b ? sop_b   : sop_a;
  assign m_eop   = use_b ? eop_b   : eop_a;
  assign m_valid = use_b ? valid_b : valid_a;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap     [0:4095];   // {eop, sop, data}
  logic [31:0] ref_cap [0:63];
  int          nbeats;

  typedef struct {
    int          beat;
    logic [29:0] data;
    logic        sop;
    logic        eop;
  } vec_t;
  vec_t tbl [0:9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] bar_rgb(input int x, input int h);
    case (x / (h / 8))
      0:       return 30'h3FFFFFFF;
      1:       return 30'h3FFFFC00;
      2:       return 30'h000FFFFF;
      3:       return 30'h000FFC00;
      4:       return 30'h3FF003FF;
      5:       return 30'h3FF00000;
      6:       return 30'h000003FF;
      default: return 30'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_beat(input logic [1:0] s, input logic [29:0] col,
                                           input int i, input int h, input int v);
    int          x = i % h;
    int          y = i / h;
    logic [9:0]  g;
    logic [29:0] p;
    g = x[9:0];
    case (s)
      2'd0:    p = bar_rgb(x, h);
      2'd1:    p = {g, g, g};
      2'd2:    p = (((x / 32) % 2) == ((y / 32) % 2)) ? 30'h3FFFFFFF : 30'h0;
      default: p = col;
    endcase
    return {(i == h * v - 1), (i == 0), p};
  endfunction

  // Accept beats until eop, optionally stalling, dropping enable or changing the pattern mid-frame.
  task automatic collect(input bit rnd, input int drop_at, input int chg_at, input int max_cyc);
    int          cyc = 0;
    bit          done = 0;
    bit          stalled;
    logic [32:0] prev;
    nbeats = 0;
    while (!done && cyc < max_cyc) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nbeats == drop_at) begin
        en_a = 1'b0;
        en_b = 1'b0;
      end
      if (nbeats == chg_at) begin
        sel   = 2'd3;
        color = SOLID;
      end
      stalled = m_valid && !ready;
      prev    = {m_valid, m_eop, m_sop, m_data};
      if (m_valid && ready) begin
        cap[nbeats] = {m_eop, m_sop, m_data};
        nbeats++;
        if (m_eop) done = 1;
      end
      step();
      cyc++;
      if (stalled) chk("stall_hold", {m_valid, m_eop, m_sop, m_data}, prev);
    end
    ready = 1'b1;
    chk("frame_done", done, 1);
  endtask

  task automatic check_frame(input string name, input logic [1:0] s, input logic [29:0] col,
                             input int h, input int v);
    int bad = 0;
    for (int i = 0; i < h * v; i++) begin
      if (cap[i] !== exp_beat(s, col, i, h, v)) bad++;
    end
    chk({name, "_beats"}, nbeats, h * v);
    chk({name, "_errs"}, bad, 0);
  endtask

  initial begin
    tbl[0] = '{0,  30'h3FFFFFFF, 1'b1, 1'b0};
    tbl[1] = '{1,  30'h3FFFFFFF, 1'b0, 1'b0};
    tbl[2] = '{2,  30'h3FFFFC00, 1'b0, 1'b0};
    tbl[3] = '{3,  30'h3FFFFC00, 1'b0, 1'b0};
    tbl[4] = '{4,  30'h000FFFFF, 1'b0, 1'b0};
    tbl[5] = '{8,  30'h3FF003FF, 1'b0, 1'b0};
    tbl[6] = '{14, 30'h00000000, 1'b0, 1'b0};
    tbl[7] = '{15, 30'h00000000, 1'b0, 1'b0};
    tbl[8] = '{16, 30'h3FFFFFFF, 1'b0, 1'b0};
    tbl[9] = '{63, 30'h00000000, 1'b0, 1'b1};

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ready = 1'b0; sel = 2'd0; color = '0; use_b = 0;
    step();
    step();
    chk("rst_outputs", {valid_a, sop_a, eop_a, busy_a, data_a}, 34'h0);
    chk("rst_fc", fc_a, 16'h0);
    rst = 1'b0;
    step();

    // Color bars, ready held high, single enable pulse.
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    chk("start_edge_n", {valid_a, busy_a}, 2'b01);
    step();
    chk("start_edge_n1", {valid_a, sop_a, data_a}, {2'b11, WHITE});
    collect(0, -1, -1, 200);
    chk("s1_beats", nbeats, 64);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("s1_vec%0d", tbl[k].beat), cap[tbl[k].beat], {tbl[k].eop, tbl[k].sop, tbl[k].data});
    end
    check_frame("s1_model", 2'd0, 30'h0, HA, VA);
    chk("s1_after", {valid_a, busy_a, fc_a}, {2'b00, 16'd1});
    for (int k = 0; k < 64; k++) ref_cap[k] = cap[k];

    // Same frame with random backpressure.
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    collect(1, -1, -1, 2000);
    begin
      int diff = 0;
      for (int k = 0; k < 64; k++) if (cap[k] !== ref_cap[k]) diff++;
      chk("s2_beats", nbeats, 64);
      chk("s2_seq_diff", diff, 0);
    end
    chk("s2_fc", fc_a, 16'd2);

    // Enable held, pattern switched mid-frame, then enable dropped at beat 20 of frame two.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s3_rst_fc", fc_a, 16'd0);
    sel = 2'd0; color = '0; en_a = 1'b1;
    step();
    collect(0, -1, 10, 300);
    check_frame("s3_f1", 2'd0, 30'h0, HA, VA);
    chk("s3_no_gap", {valid_a, sop_a, data_a}, {2'b11, SOLID});
    chk("s3_fc1", {busy_a, fc_a}, {1'b1, 16'd1});
    collect(0, 20, -1, 300);
    check_frame("s4_f2", 2'd3, SOLID, HA, VA);
    chk("s4_after", {valid_a, busy_a, fc_a}, {2'b00, 16'd2});

    // Checkerboard and gradient on the 64x64 instance.
    use_b = 1; sel = 2'd2;
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    collect(0, -1, -1, 5000);
    chk("s5_chk_0_0", cap[0][29:0], WHITE);
    chk("s5_chk_32_0", cap[32][29:0], 30'h0);
    chk("s5_chk_32_32", cap[32 * 64 + 32][29:0], WHITE);
    check_frame("s5_chk", 2'd2, 30'h0, HB, VB);
    sel = 2'd1;
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    collect(0, -1, -1, 5000);
    chk("s5_grad_5_0", cap[5][29:0], 30'h00501405);
    chk("s5_grad_5_7", cap[7 * 64 + 5][29:0], 30'h00501405);
    chk("s5_grad_63_0", cap[63][29:0], 30'h03F0FC3F);
    check_frame("s5_grad", 2'd1, 30'h0, HB, VB);
    chk("s5_fc", fc_b, 16'd2);

    // Reset at beat 10 abandons the frame.
    use_b = 0; sel = 2'd0;
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    for (int k = 0; k < 10; k++) step();
    chk("s6_pre_rst_valid", valid_a, 1'b1);
    rst = 1'b1;
    step();
    chk("s6_rst_outputs", {valid_a, sop_a, eop_a, busy_a, data_a}, 34'h0);
    chk("s6_rst_fc", fc_a, 16'h0);
    rst = 1'b0;
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    step();
    chk("s6_restart", {valid_a, sop_a, data_a}, {2'b11, WHITE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_pattern_source.md
# vga_pattern_source

Avalon-ST video source that generates full frames of 30-bit RGB pixels (10 bits per channel) with start/end-of-packet framing and honours the sink's ready backpressure. It drives the VGA controller's stream sink from the fabric side, supplying test patterns (color bars, gradient, checkerboard, solid color) for bring-up and display verification without a frame buffer.

## Interface

Parameters:
- H_ACTIVE, 640, pixels per line; must be divisible by 8 and ≤ 4096
- V_ACTIVE, 480, lines per frame; ≤ 4096

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- enable  in  1  level; permits starting a new frame
- pattern_sel  in  2  0 color bars, 1 gray gradient, 2 checkerboard, 3 solid
- solid_color  in  30  RGB used by pattern 3
- stream_data  out  30  pixel: [29:20] R, [19:10] G, [9:0] B
- stream_startofpacket  out  1  high on pixel (0,0) only
- stream_endofpacket  out  1  high on pixel (H_ACTIVE-1, V_ACTIVE-1) only
- stream_valid  out  1  beat present
- stream_ready  in  1  sink accepts beat; readyLatency 0
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- busy  out  1  high while in STREAM state

## Operation

- States: IDLE, STREAM.
- IDLE: valid=0. If enable=1: latch pattern_sel and solid_color, set x=0, y=0, go STREAM.
- STREAM: valid=1; present pixel (x,y). Transfer occurs when valid && ready.
- On transfer: x++; at x=H_ACTIVE-1, x←0 and y++. On last pixel transfer: frame_count++; if enable=1 stay STREAM with x=y=0 and relatch pattern_sel/solid_color (no bubble); else go IDLE.
- pattern_sel and solid_color changes mid-frame have no effect until the next frame latch.
- Deasserting enable mid-frame does not truncate; frame completes through eop.
- Pattern 0: bar index 0..7 = x / (H_ACTIVE/8), tracked with a bar-width counter and index counter reset at line start (no divider). Colors in order: white, yellow, cyan, green, magenta, red, blue, black; each channel 0x3FF or 0x000. White=0x3FFFFFFF, yellow=0x3FFFFC00.
- Pattern 1: R=G=B=x[9:0] (mod 1024).
- Pattern 2: white when x[5]^y[5]=0, else black (32×32 squares).
- Pattern 3: latched solid_color.
- sop = (x==0 && y==0); eop = (x==H_ACTIVE-1 && y==V_ACTIVE-1); both qualified by valid.

## Timing

- All outputs registered; no combinational path from stream_ready or enable to any output.
- Reset values: stream_data=0, sop=0, eop=0, valid=0, frame_count=0, busy=0; state IDLE, x=y=0, bar counters 0.
- Reset mid-frame: next cycle all outputs at reset values; partial frame abandoned, not counted.
- Start latency: enable sampled high in IDLE at edge N → valid=1 with sop and pixel (0,0) after edge N+1.
- While valid && !ready: data, sop, eop held stable; counters frozen.
- Throughput: one pixel per cycle with ready held high; back-to-back frames have no idle cycle between eop and next sop.
- frame_count updates on the edge that accepts the eop beat.

## Test plan

- Reset, then H_ACTIVE=16, V_ACTIVE=4, sel=0, ready=1, enable pulse → valid rises next cycle, sop with 0x3FFFFFFF; pixels 2–3 0x3FFFFC00; pixels 14–15 0x00000000; exactly 64 beats, eop on 64th; frame_count=1; busy=0 after.
- Random ready (≈50%) on same frame → data/sop/eop stable in every stalled cycle; 64 accepted beats, sequence identical to scenario 1.
- enable held, sel changed 0→3 (solid_color=0x12345678 masked to 30 bits) mid-frame → current frame stays color bars; next sop follows eop with zero gap and carries solid color; frame_count=2.
- enable dropped at beat 20 → frame finishes with eop at beat 64, valid=0 next cycle, busy=0.
- H_ACTIVE=64, V_ACTIVE=64, sel=2 → (0,0)=0x3FFFFFFF, (32,0)=0, (32,32)=0x3FFFFFFF; sel=1 → pixel (5,y)=0x00501405.
- reset_reset asserted at beat 10 → next cycle valid=0, frame_count=0; after release with enable, sop at (0,0).
